// File: rtl/nebula_pkg.sv
// Shared Nebula router types: flit format, port count and output-allocator FSM states.
package nebula_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned FLIT_W    = 16;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [0:0] {
        ALLOC  = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/nebula_credit_counter.sv
// Downstream credit counter: starts full, pop decrements, credit return increments,
// saturating at CREDIT_DEPTH and never underflowing.
module nebula_credit_counter #(
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned CRED_W       = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec,
    input  logic              inc,
    output logic [CRED_W-1:0] count,
    output logic              has_credit
);

    localparam logic [CRED_W-1:0] FULL = CRED_W'(CREDIT_DEPTH);

    logic [CRED_W-1:0] r_count;
    logic [CRED_W-1:0] w_count_next;
    logic              w_full;
    logic              w_empty;

    assign w_full     = (r_count == FULL);
    assign w_empty    = (r_count == '0);
    assign count      = r_count;
    assign has_credit = !w_empty;

    // A pop and a returned credit in the same cycle cancel out.
    always_comb begin
        w_count_next = r_count;
        if (inc && !dec && !w_full) begin
            w_count_next = r_count + CRED_W'(1);
        end else if (dec && !inc && !w_empty) begin
            w_count_next = r_count - CRED_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= FULL;
        end else begin
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && inc && !dec) begin
            assert (!w_full)
            else $warning("credit returned while counter already full; ignored");
        end
        if (!rst && dec) begin
            assert (!w_empty)
            else $error("pop issued with no credit available");
        end
    end

endmodule

// File: rtl/nebula_output_alloc.sv
// Per-output allocator: head requests to the arbiter, wormhole lock to the winner, credit-gated
// registered flit forwarding. Define NEBULA_OUT_ALLOC_STATS_EN for stat_flits/stat_pkts.
module nebula_output_alloc
    import nebula_pkg::*;
#(
    parameter int unsigned NUM_REQS     = NUM_PORTS,
    parameter int unsigned REQ_WIDTH    = $clog2(NUM_REQS),
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned CRED_W       = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQS-1:0]  in_valid,
    input  flit_t                in_flit [NUM_REQS],
    input  logic [NUM_REQS-1:0]  in_head,
    input  logic [NUM_REQS-1:0]  in_tail,
    output logic [NUM_REQS-1:0]  in_pop,
    output logic [NUM_REQS-1:0]  arb_req,
    input  logic [NUM_REQS-1:0]  arb_grant,
    input  logic                 arb_grant_valid,
    input  logic [REQ_WIDTH-1:0] arb_grant_id,
    output logic                 out_valid,
    output flit_t                out_flit,
    input  logic                 credit_in,
    output logic                 lock_active,
    output logic [REQ_WIDTH-1:0] lock_owner
`ifdef NEBULA_OUT_ALLOC_STATS_EN
    ,
    output logic [31:0]          stat_flits,
    output logic [31:0]          stat_pkts
`endif
);

    alloc_state_e         r_state;
    alloc_state_e         w_state_next;
    logic [REQ_WIDTH-1:0] r_owner;
    logic [REQ_WIDTH-1:0] w_owner_next;
    logic                 r_lock_active;
    logic                 r_out_valid;
    flit_t                r_out_flit;

    logic [CRED_W-1:0]    w_credit_count;
    logic                 w_has_credit;
    logic [NUM_REQS-1:0]  w_head_req;
    logic [NUM_REQS-1:0]  w_grant_onehot;
    logic                 w_id_in_range;
    logic                 w_grant_ok;
    logic [REQ_WIDTH-1:0] w_sel;
    logic                 w_pop_any;

    assign w_head_req     = in_valid & in_head;
    assign w_id_in_range  = (32'(arb_grant_id) < NUM_REQS);
    assign w_grant_onehot = NUM_REQS'(1) << arb_grant_id;

    // A grant is honoured only if the one-hot and binary forms agree and point at a live head.
    assign w_grant_ok = arb_grant_valid && w_id_in_range && w_has_credit
                        && (arb_grant == w_grant_onehot)
                        && ((w_head_req & w_grant_onehot) != '0);

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_sel        = r_owner;
        in_pop       = '0;
        arb_req      = '0;
        if (!rst) begin
            case (r_state)
                ALLOC: begin
                    if (w_has_credit) begin
                        arb_req = w_head_req;
                    end
                    if (w_grant_ok) begin
                        w_sel        = arb_grant_id;
                        in_pop       = w_grant_onehot;
                        w_owner_next = arb_grant_id;
                        if (!in_tail[arb_grant_id]) begin
                            w_state_next = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    // Requests stay low so the arbiter's priority does not move mid-packet.
                    if (in_valid[r_owner] && w_has_credit) begin
                        in_pop = NUM_REQS'(1) << r_owner;
                        if (in_tail[r_owner]) begin
                            w_state_next = ALLOC;
                        end
                    end
                end
                default: w_state_next = ALLOC;
            endcase
        end
    end

    assign w_pop_any = |in_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ALLOC;
            r_owner       <= '0;
            r_lock_active <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_flit    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_owner       <= w_owner_next;
            r_lock_active <= (w_state_next == LOCKED);
            r_out_valid   <= w_pop_any;
            if (w_pop_any) begin
                r_out_flit <= in_flit[w_sel];
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_flit    = r_out_flit;
    assign lock_active = r_lock_active;
    assign lock_owner  = r_owner;

    nebula_credit_counter #(
        .CREDIT_DEPTH (CREDIT_DEPTH),
        .CRED_W       (CRED_W)
    ) u_credit_counter (
        .clk        (clk),
        .rst        (rst),
        .dec        (w_pop_any),
        .inc        (credit_in),
        .count      (w_credit_count),
        .has_credit (w_has_credit)
    );

    always_ff @(posedge clk) begin
        if (!rst && r_state == ALLOC && arb_grant_valid) begin
            assert (w_grant_ok)
            else $warning("grant without matching head request; ignored");
        end
        if (!rst) begin
            assert ($onehot0(in_pop))
            else $error("in_pop is not one-hot");
            assert (w_credit_count <= CRED_W'(CREDIT_DEPTH))
            else $error("credit count above depth");
        end
    end

`ifdef NEBULA_OUT_ALLOC_STATS_EN
    logic [31:0] r_stat_flits;
    logic [31:0] r_stat_pkts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_flits <= '0;
            r_stat_pkts  <= '0;
        end else begin
            if (w_pop_any) begin
                r_stat_flits <= r_stat_flits + 32'd1;
            end
            if (w_pop_any && in_tail[w_sel]) begin
                r_stat_pkts <= r_stat_pkts + 32'd1;
            end
        end
    end

    assign stat_flits = r_stat_flits;
    assign stat_pkts  = r_stat_pkts;
`endif

endmodule

// File: tb/tb_nebula_output_alloc.sv
// Directed bench for nebula_output_alloc: a depth-4 instance plus a depth-2 instance for the
// credit-stall case, fed by a simple per-port input-buffer model.
`timescale 1ns/1ps
module tb_nebula_output_alloc;
    import nebula_pkg::*;

    localparam int N  = NUM_PORTS;
    localparam int RW = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  in_valid;
    flit_t         in_flit [N];
    logic [N-1:0]  in_head;
    logic [N-1:0]  in_tail;
    logic [N-1:0]  arb_grant;
    logic          arb_grant_valid;
    logic [RW-1:0] arb_grant_id;
    logic          credit_in;

    logic [N-1:0]  in_pop, arb_req, pop2, req2;
    logic          out_valid, ov2, lock_active, lock2;
    flit_t         out_flit, flit2;
    logic [RW-1:0] lock_owner, own2;

    nebula_output_alloc #(
        .CREDIT_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_flit         (in_flit),
        .in_head         (in_head),
        .in_tail         (in_tail),
        .in_pop          (in_pop),
        .arb_req         (arb_req),
        .arb_grant       (arb_grant),
        .arb_grant_valid (arb_grant_valid),
        .arb_grant_id    (arb_grant_id),
        .out_valid       (out_valid),
        .out_flit        (out_flit),
        .credit_in       (credit_in),
        .lock_active     (lock_active),
        .lock_owner      (lock_owner)
    );

    nebula_output_alloc #(
        .CREDIT_DEPTH (2)
    ) dut2 (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_flit         (in_flit),
        .in_head         (in_head),
        .in_tail         (in_tail),
        .in_pop          (pop2),
        .arb_req         (req2),
        .arb_grant       (arb_grant),
        .arb_grant_valid (arb_grant_valid),
        .arb_grant_id    (arb_grant_id),
        .out_valid       (ov2),
        .out_flit        (flit2),
        .credit_in       (credit_in),
        .lock_active     (lock2),
        .lock_owner      (own2)
    );

    // Input-buffer model; pops follow whichever instance is under test (sel2).
    flit_t q_flit [N][8];
    logic  q_head [N][8];
    logic  q_tail [N][8];
    int    q_len  [N];
    int    q_rd   [N];
    bit    sel2;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic flush();
        for (int p = 0; p < N; p++) begin
            q_len[p] = 0;
            q_rd[p]  = 0;
        end
    endtask

    task automatic push(input int p, input flit_t f, input logic h, input logic t);
        q_flit[p][q_len[p]] = f;
        q_head[p][q_len[p]] = h;
        q_tail[p][q_len[p]] = t;
        q_len[p]++;
    endtask

    task automatic present();
        for (int p = 0; p < N; p++) begin
            if (q_rd[p] < q_len[p]) begin
                in_valid[p] = 1'b1;
                in_flit[p]  = q_flit[p][q_rd[p]];
                in_head[p]  = q_head[p][q_rd[p]];
                in_tail[p]  = q_tail[p][q_rd[p]];
            end else begin
                in_valid[p] = 1'b0;
                in_flit[p]  = '0;
                in_head[p]  = 1'b0;
                in_tail[p]  = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, check mid-cycle, advance the buffer model past the edge.
    task automatic cyc(input string tag, input bit gv, input int gid, input bit cin,
                       input logic [N-1:0] e_pop, input logic [N-1:0] e_req, input bit e_ov,
                       input flit_t e_flit, input bit e_lock, input int e_own, input int e_cred);
        logic [N-1:0] pop;
        present();
        arb_grant_valid = gv;
        arb_grant_id    = RW'(gid);
        arb_grant       = gv ? (N'(1) << gid) : '0;
        credit_in       = cin;
        #4;
        pop = sel2 ? pop2 : in_pop;
        check_eq({tag, ".pop"}, 32'(pop), 32'(e_pop));
        check_eq({tag, ".req"}, 32'(sel2 ? req2 : arb_req), 32'(e_req));
        check_eq({tag, ".out_valid"}, 32'(sel2 ? ov2 : out_valid), 32'(e_ov));
        if (e_ov) begin
            check_eq({tag, ".out_flit"}, 32'(sel2 ? flit2 : out_flit), 32'(e_flit));
        end
        check_eq({tag, ".lock"}, 32'(sel2 ? lock2 : lock_active), 32'(e_lock));
        check_eq({tag, ".owner"}, 32'(sel2 ? own2 : lock_owner), 32'(e_own));
        check_eq({tag, ".credits"},
                 sel2 ? 32'(dut2.w_credit_count) : 32'(dut.w_credit_count), 32'(e_cred));
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (pop[p]) q_rd[p]++;
        end
        arb_grant_valid = 1'b0;
        arb_grant       = '0;
        credit_in       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        present();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        sel2            = 1'b0;
        arb_grant       = '0;
        arb_grant_valid = 1'b0;
        arb_grant_id    = '0;
        credit_in       = 1'b0;

        // Reset values, then a stray grant that must change nothing.
        do_reset();
        check_eq("rst.out_flit", 32'(out_flit), 32'h0);
        cyc("rst",       0, 0, 0, 5'b00000, 5'b00000, 0, 16'h0, 0, 0, 4);
        cyc("stray",     1, 4, 0, 5'b00000, 5'b00000, 0, 16'h0, 0, 0, 4);
        cyc("stray_aft", 0, 0, 0, 5'b00000, 5'b00000, 0, 16'h0, 0, 0, 4);

        // Single 3-flit packet on port 2.
        do_reset();
        push(2, 16'h0201, 1, 0);
        push(2, 16'h0202, 0, 0);
        push(2, 16'h0203, 0, 1);
        cyc("p3f.c0", 1, 2, 0, 5'b00100, 5'b00100, 0, 16'h0,    0, 0, 4);
        cyc("p3f.c1", 0, 0, 0, 5'b00100, 5'b00000, 1, 16'h0201, 1, 2, 3);
        cyc("p3f.c2", 0, 0, 0, 5'b00100, 5'b00000, 1, 16'h0202, 1, 2, 2);
        cyc("p3f.c3", 0, 0, 0, 5'b00000, 5'b00000, 1, 16'h0203, 0, 2, 1);
        cyc("p3f.c4", 0, 0, 0, 5'b00000, 5'b00000, 0, 16'h0,    0, 2, 1);

        // Competing 2-flit packets on ports 0 and 3, draining credits to zero.
        do_reset();
        push(0, 16'h0001, 1, 0);
        push(0, 16'h0002, 0, 1);
        push(3, 16'h0301, 1, 0);
        push(3, 16'h0302, 0, 1);
        cyc("cmp.c0", 1, 0, 0, 5'b00001, 5'b01001, 0, 16'h0,    0, 0, 4);
        cyc("cmp.c1", 0, 0, 0, 5'b00001, 5'b00000, 1, 16'h0001, 1, 0, 3);
        cyc("cmp.c2", 1, 3, 0, 5'b01000, 5'b01000, 1, 16'h0002, 0, 0, 2);
        cyc("cmp.c3", 0, 0, 0, 5'b01000, 5'b00000, 1, 16'h0301, 1, 3, 1);
        cyc("cmp.c4", 0, 0, 0, 5'b00000, 5'b00000, 1, 16'h0302, 0, 3, 0);
        push(1, 16'h0101, 1, 1);
        cyc("zcr.c5", 0, 0, 1, 5'b00000, 5'b00000, 0, 16'h0,    0, 3, 0);
        cyc("zcr.c6", 1, 1, 0, 5'b00010, 5'b00010, 0, 16'h0,    0, 3, 1);
        cyc("zcr.c7", 0, 0, 0, 5'b00000, 5'b00000, 1, 16'h0101, 0, 1, 0);

        // Credit stall on the depth-2 instance.
        do_reset();
        sel2 = 1'b1;
        push(1, 16'h0111, 1, 0);
        push(1, 16'h0112, 0, 0);
        push(1, 16'h0113, 0, 0);
        push(1, 16'h0114, 0, 1);
        cyc("stl.c0", 1, 1, 0, 5'b00010, 5'b00010, 0, 16'h0,    0, 0, 2);
        cyc("stl.c1", 0, 0, 0, 5'b00010, 5'b00000, 1, 16'h0111, 1, 1, 1);
        cyc("stl.c2", 0, 0, 0, 5'b00000, 5'b00000, 1, 16'h0112, 1, 1, 0);
        cyc("stl.c3", 0, 0, 1, 5'b00000, 5'b00000, 0, 16'h0,    1, 1, 0);
        cyc("stl.c4", 0, 0, 0, 5'b00010, 5'b00000, 0, 16'h0,    1, 1, 1);
        cyc("stl.c5", 0, 0, 0, 5'b00000, 5'b00000, 1, 16'h0113, 1, 1, 0);
        cyc("stl.c6", 0, 0, 0, 5'b00000, 5'b00000, 0, 16'h0,    1, 1, 0);
        sel2 = 1'b0;

        // Single-flit packets back to back, then pop+credit at 1 and saturation at full.
        do_reset();
        push(1, 16'h0151, 1, 1);
        push(4, 16'h0451, 1, 1);
        cyc("sgl.c0", 1, 1, 0, 5'b00010, 5'b10010, 0, 16'h0,    0, 0, 4);
        cyc("sgl.c1", 1, 4, 0, 5'b10000, 5'b10000, 1, 16'h0151, 0, 1, 3);
        cyc("sgl.c2", 0, 0, 0, 5'b00000, 5'b00000, 1, 16'h0451, 0, 4, 2);
        cyc("sgl.c3", 0, 0, 0, 5'b00000, 5'b00000, 0, 16'h0,    0, 4, 2);
        push(2, 16'h0261, 1, 1);
        cyc("pc.c4",  1, 2, 0, 5'b00100, 5'b00100, 0, 16'h0,    0, 4, 2);
        push(3, 16'h0361, 1, 1);
        cyc("pc.c5",  1, 3, 1, 5'b01000, 5'b01000, 1, 16'h0261, 0, 2, 1);
        cyc("pc.c6",  0, 0, 1, 5'b00000, 5'b00000, 1, 16'h0361, 0, 3, 1);
        cyc("sat.c7", 0, 0, 1, 5'b00000, 5'b00000, 0, 16'h0,    0, 3, 2);
        cyc("sat.c8", 0, 0, 1, 5'b00000, 5'b00000, 0, 16'h0,    0, 3, 3);
        cyc("sat.c9", 0, 0, 1, 5'b00000, 5'b00000, 0, 16'h0,    0, 3, 4);
        cyc("sat.c10", 0, 0, 0, 5'b00000, 5'b00000, 0, 16'h0,   0, 3, 4);

        // Reset after head and body of a 4-flit packet, then a fresh packet from port 0.
        do_reset();
        push(3, 16'h0371, 1, 0);
        push(3, 16'h0372, 0, 0);
        push(3, 16'h0373, 0, 0);
        push(3, 16'h0374, 0, 1);
        cyc("rm.c0", 1, 3, 0, 5'b01000, 5'b01000, 0, 16'h0,    0, 0, 4);
        cyc("rm.c1", 0, 0, 0, 5'b01000, 5'b00000, 1, 16'h0371, 1, 3, 3);
        rst = 1'b1;
        cyc("rm.c2", 0, 0, 0, 5'b00000, 5'b00000, 1, 16'h0372, 1, 3, 2);
        rst = 1'b0;
        flush();
        check_eq("rm.out_flit", 32'(out_flit), 32'h0);
        push(0, 16'h0081, 1, 0);
        push(0, 16'h0082, 0, 1);
        cyc("rm.c3", 1, 0, 0, 5'b00001, 5'b00001, 0, 16'h0,    0, 0, 4);
        cyc("rm.c4", 0, 0, 0, 5'b00001, 5'b00000, 1, 16'h0081, 1, 0, 3);
        cyc("rm.c5", 0, 0, 0, 5'b00000, 5'b00000, 1, 16'h0082, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
